// File: rtl/byte_lane_serializer.sv
// -----------------------------------------------------------------------------
// byte_lane_serializer
//
// Down-converts one IN_W-bit word into a stream of OUT_W-bit symbols for the
// byte-oriented encoder in the transmit path. The lane count of each word is
// chosen by `mode` when the word is accepted:
//   lanes = min(2^mode, IN_W/OUT_W).
// Consecutive words stream with no bubble: the final symbol of one word and the
// accept of the next word happen on the same clock edge.
//
// Build option:
//   BLS_MSB_FIRST_EN  defined   -> lanes go out most-significant first
//                                  (lane L-1 ... lane 0)
//                     undefined -> lanes go out least-significant first
//                                  (lane 0 ... lane L-1)
//
// Parameters:
//   IN_W   input word width, OUT_W times a power of two (>= 1)
//   OUT_W  output symbol width
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   mode       in   lane count selector for the word being accepted
//   in_data    in   input word, lane 0 = bits [OUT_W-1:0]
//   in_valid   in   in_data/mode valid
//   in_ready   out  a word can be accepted this cycle (combinational)
//   out_data   out  current symbol (registered)
//   out_valid  out  out_data valid (registered)
//   out_ready  in   downstream consumes the symbol this cycle
//   out_last   out  current symbol is the final lane of its word (combinational)
//   busy       out  a word is held (same as out_valid)
// -----------------------------------------------------------------------------
module byte_lane_serializer #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int LANES_MAX = IN_W / OUT_W;
    localparam int LOG_LANES = $clog2(LANES_MAX);
    localparam int CNT_W     = (LOG_LANES < 1) ? 1 : LOG_LANES;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IN_W-1:0]   sh_q, sh_d;

    logic [CNT_W-1:0]  lanes_m1;
    logic [IN_W-1:0]   load_word;
    logic              accept;
    logic              consume;

    assign out_valid = (state_q == SEND);
    assign busy      = out_valid;
    assign out_last  = out_valid && (cnt_q == '0);
    assign in_ready  = !out_valid || (out_ready && out_last);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

`ifdef BLS_MSB_FIRST_EN
    // The output lane is the top of the register; the word is shifted up.
    assign out_data = sh_q[IN_W-1 -: OUT_W];
`else
    // The output lane is the bottom of the register; the word is shifted down.
    assign out_data = sh_q[OUT_W-1:0];
`endif

    always_comb begin
        // Modes asking for more lanes than the word holds clamp to the maximum.
        lanes_m1 = CNT_W'(LANES_MAX - 1);
        if (int'(mode) < LOG_LANES) begin
            lanes_m1 = CNT_W'((1 << mode) - 1);
        end

`ifdef BLS_MSB_FIRST_EN
        // Left-justify the L used lanes so lane L-1 sits in the output slot;
        // unused upper lanes fall off the top and never reach the output.
        load_word = in_data << ((LANES_MAX - 1 - int'(lanes_m1)) * OUT_W);
`else
        // Unused upper lanes stay above the L used lanes and are never shifted
        // down into the output slot before the word completes.
        load_word = in_data;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;

        // Accept only happens when the register is empty or its last symbol
        // is leaving at this same edge, so it overrides the consume update.
        if (accept) begin
            state_d = SEND;
            cnt_d   = lanes_m1;
            sh_d    = load_word;
        end else if (consume) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
`ifdef BLS_MSB_FIRST_EN
                sh_d  = sh_q << OUT_W;
`else
                sh_d  = sh_q >> OUT_W;
`endif
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

endmodule
